// File: rtl/keypad_decoder.sv
// keypad_decoder: assembles 5-clock scan frames from row drive and column sense,
// debounces at frame granularity and emits one-shot key events.
module keypad_decoder #(
    parameter int DEB_FRAMES = 3,
    parameter int REL_FRAMES = 2
) (
    input  logic       clk_sec,
    input  logic       rst_n,
    input  logic [3:0] ent_teclado,
    input  logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);
    localparam logic [3:0] DEB = 4'(DEB_FRAMES);
    localparam logic [3:0] REL = 4'(REL_FRAMES);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n, cand, cand_n, rows_seen, hit_code;
    logic       hit, amb, accept;
    logic       eval, row_phase, col_one, col_multi, frame_ok, f_single, f_empty;
    logic [1:0] r, c;

    assign eval      = ent_teclado == 4'b1111;
    assign row_phase = $onehot(ent_teclado);
    assign col_one   = $onehot(col);
    assign col_multi = (col != 4'b0000) && !col_one;
    assign r = ent_teclado[3] ? 2'd0 : ent_teclado[2] ? 2'd1 : ent_teclado[1] ? 2'd2 : 2'd3;
    assign c = col[3] ? 2'd0 : col[2] ? 2'd1 : col[1] ? 2'd2 : 2'd3;
    // A frame only counts once every row has been sampled since the last evaluation.
    assign frame_ok = eval && rows_seen == 4'b1111;
    assign f_single = frame_ok && !amb && hit;
    assign f_empty  = frame_ok && !amb && !hit;

    always_ff @(posedge clk_sec or negedge rst_n) begin
        if (!rst_n) begin
            rows_seen <= '0;
            hit       <= 1'b0;
            hit_code  <= '0;
            amb       <= 1'b0;
        end else if (eval) begin
            rows_seen <= '0;
            hit       <= 1'b0;
            hit_code  <= '0;
            amb       <= 1'b0;
        end else if (row_phase) begin
            rows_seen[r] <= 1'b1;
            if (col_one) begin
                hit      <= 1'b1;
                hit_code <= {r, c};
                if (hit) amb <= 1'b1;
            end
            if (col_multi) amb <= 1'b1;
        end else begin
            amb <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        accept  = 1'b0;
        if (frame_ok) begin
            case (state)
                IDLE: if (f_single) begin
                    cand_n = hit_code;
                    if (DEB == 4'd1) begin
                        state_n = HELD;
                        accept  = 1'b1;
                    end else begin
                        state_n = DEBOUNCE;
                        cnt_n   = 4'd1;
                    end
                end
                DEBOUNCE: if (!f_single) begin
                    state_n = IDLE;
                end else if (hit_code == cand) begin
                    cnt_n = cnt + 4'd1;
                    if (cnt + 4'd1 == DEB) begin
                        state_n = HELD;
                        accept  = 1'b1;
                    end
                end else begin
                    cand_n = hit_code;
                    cnt_n  = 4'd1;
                end
                HELD: if (f_empty) begin
                    state_n = (REL == 4'd1) ? IDLE : RELEASE;
                    cnt_n   = 4'd1;
                end
                RELEASE: if (f_empty) begin
                    cnt_n = cnt + 4'd1;
                    if (cnt + 4'd1 == REL) state_n = IDLE;
                end else begin
                    state_n = HELD;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sec or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_valid <= accept;
            key_code  <= accept ? cand_n : key_code;
            key_held  <= (state_n == HELD) || (state_n == RELEASE);
        end
    end
endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Keypad column sense and decode stage sitting directly downstream of the row scanner. It takes the scanner's 4-bit row drive `ent_teclado`, which cycles 1111 → 1000 → 0100 → 0010 → 0001, and the 4 keypad column lines. It assembles one scan frame per five clocks, debounces at frame granularity, and emits a single-cycle `key_valid` pulse with a 4-bit key code per accepted press. It feeds the game/colour-selection logic, which only needs clean one-shot key events.

## Interface
- `DEB_FRAMES`, default 3: consecutive identical single-key frames required to accept a press (legal 1..15).
- `REL_FRAMES`, default 2: consecutive empty frames required to accept a release (legal 1..15).

Ports:
- `clk_sec` in 1: the single system clock, the same clock that advances the row scanner.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ent_teclado` in 4: row drive from the scanner; it is already registered in the `clk_sec` domain.
- `col` in 4: column sense, active-high; driven high when a key on a driven row is pressed; synchronous to `clk_sec`.
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_code` out 4: code of the last accepted key; holds between presses.
- `key_held` out 1: high while an accepted key is considered pressed.

## Operation
- **Row index** r from `ent_teclado`: 1000→0, 0100→1, 0010→2, 0001→3. **Column index** c from `col`: bit3→0, bit2→1, bit1→2, bit0→3. **Code** = 4·r + c, so row 1000 with col 1000 gives 0 and row 0001 with col 0001 gives 15.
- **Row-phase sample.** On each edge where `ent_teclado` is a one-hot row value:
  - Set bit r of `rows_seen`.
  - `col` = 0000: no contribution.
  - `col` one-hot: records a hit (code). A second hit in the same frame marks the frame ambiguous.
  - `col` with more than one bit set: marks the frame ambiguous.
- **Illegal drive.** Any `ent_teclado` value other than 1111 or one-hot marks the frame ambiguous.
- **Frame evaluation** happens on the edge where `ent_teclado` = 1111 is sampled. `col` is ignored in this phase. The frame classifies as:
  - discarded: `rows_seen` ≠ 1111. This covers the partial first frame after reset.
  - ambiguous.
  - empty: no hits.
  - single(k): exactly one hit.
  - On that same edge, the frame accumulators (`rows_seen`, hit, ambiguous flag) clear.
- **FSM, states IDLE/DEBOUNCE/HELD/RELEASE.** `cnt` is a 4-bit counter.
  - **IDLE:** single(k) → `cand`=k.
    - If `DEB_FRAMES`=1: go to HELD and fire the accept.
    - Otherwise: go to DEBOUNCE with `cnt`=1.
    - Any other class: stay in IDLE.
  - **DEBOUNCE:**
    - single(`cand`) → `cnt`+1. When it reaches `DEB_FRAMES`, go to HELD and fire the accept.
    - single(j≠`cand`) → `cand`=j, `cnt`=1, stay in DEBOUNCE.
    - empty or ambiguous → IDLE.
  - **HELD:**
    - empty → if `REL_FRAMES`=1, go to IDLE; otherwise go to RELEASE with `cnt`=1.
    - single or ambiguous → stay in HELD. A different key never retriggers.
  - **RELEASE:**
    - empty → `cnt`+1. When it reaches `REL_FRAMES`, go to IDLE.
    - single or ambiguous → back to HELD.
  - A discarded frame causes no transition and leaves counters unchanged, in every state.
- **Accept:** `key_code` ← `cand` and `key_valid` ← 1 for exactly one cycle.
- **`key_held`** = 1 in HELD and RELEASE.

## Timing
- **Reset (async, `rst_n`=0):**
  - State IDLE; `cnt`, `cand` and frame accumulators cleared.
  - `key_valid`=0, `key_code`=0000, `key_held`=0.
- **Reset asserted mid-frame or mid-debounce** aborts immediately. After release, the first frame is discarded unless all four rows are sampled after reset.
- **Outputs** are registered. They update on the frame-evaluation edge and are visible in the cycle after it.
- **One frame** = 5 clocks. With a key stable from the start of a full frame, `key_valid` rises after the DEB_FRAMES-th evaluation edge: latency is DEB_FRAMES·5 clocks from the start of the first frame.
- **`key_valid` spacing:** at most one pulse per evaluation edge, and never in consecutive cycles.
- **Release:** `key_held` falls after the REL_FRAMES-th consecutive empty evaluation edge.

## Test plan
- Reset, then drive the scanner sequence and press row 0100 / col 0010 (code 6) for 4 full frames → exactly one `key_valid` pulse with `key_code`=6, after the 3rd evaluation edge; `key_held`=1.
- Hold code 6 for 10 frames, release for 2 frames → no further pulses; `key_held` drops after the 2nd empty evaluation edge; `key_code` stays 6.
- Bounce pattern press, press, empty, press, press, press → DEBOUNCE aborts to IDLE at the empty frame; pulse only after the 3rd consecutive press frame.
- Two keys in one frame (rows 1000 and 0001 both hit), or `col`=0110 → ambiguous; no pulse; an in-progress DEBOUNCE returns to IDLE.
- Release `rst_n` while `ent_teclado`=0010 with key 15 pressed → the partial frame is discarded; `key_valid` fires after 3 complete frames, with `key_code`=15.
- `DEB_FRAMES`=1, `REL_FRAMES`=1: press 0 for 1 frame, empty 1 frame, press 0 again → two pulses, one evaluation edge after each press frame; `key_held` toggles 1, 0, 1.
